// File: rtl/axi_mm_pkg.sv
// Shared types and constants for the arbitrated AXI4 master bridge.
//   state_t        : bridge FSM states
//   AXI_BURST_INCR : AxBURST encoding for incrementing bursts
//   AXI_RESP_OKAY  : xRESP encoding for a good response
//   size_from_strb : AxSIZE for a full-width beat given the strobe width
package axi_mm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AxSIZE is log2 of the bytes per beat; strobe width is a power of two.
    function automatic logic [2:0] size_from_strb(input int strb_w);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == strb_w) size = 3'(i);
        end
        return size;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The search starts at an internal pointer; when a
// grant is taken (advance high and some request present) the pointer moves
// to the port after the winner, so the winner drops to lowest priority.
//   clk, rst  : clock, asynchronous active-high reset (pointer -> 0)
//   req       : one bit per requester
//   advance   : consume the current grant and rotate the pointer
//   grant     : one-hot winner (all zero when no request)
//   grant_idx : binary index of the winner
module rr_arbiter #(
    parameter int  NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a value held (no latch inferred).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end

    // NOTE: sequential state is updated only with non-blocking '<='.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/axi_multi_master.sv
// Shared AXI4 master: round-robin arbitrates NUM_REQ core-side request ports
// onto one AXI4 master, one transaction outstanding at a time.
//   clk, rst             : clock, asynchronous active-high reset
//   req_*                : per-port request (valid/write/burst/addr/wdata/strb)
//   req_ready            : one-hot, one-cycle acceptance of a request
//   resp_valid/data/last/err : one-hot per-port read beat or write completion
//   busy                 : a transaction is in flight
//   ar*/r*/aw*/w*/b*     : AXI4 master channels
// The AXI ID carries the granted port index, so responses with a foreign ID
// are accepted and discarded.
module axi_multi_master
    import axi_mm_pkg::*;
#(
    parameter int  NUM_REQ   = 2,
    parameter int  ADDR_W    = 32,
    parameter int  DATA_W    = 32,
    parameter int  ID_W      = 4,
    parameter int  BURST_LEN = 4,
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ-1:0]        req_burst,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0] req_strb,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_last,
    output logic                      resp_err,
    output logic                      busy,
    output logic [ID_W-1:0]           arid,
    output logic [ADDR_W-1:0]         araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [ID_W-1:0]           rid,
    input  logic [DATA_W-1:0]         rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    output logic [ID_W-1:0]           awid,
    output logic [ADDR_W-1:0]         awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_W-1:0]         wdata,
    output logic [STRB_W-1:0]         wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [ID_W-1:0]           bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);

    localparam int         IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] AXSIZE = size_from_strb(STRB_W);

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                any_grant;

    logic [IDX_W-1:0]    gnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic                burst_q;
    logic                aw_done, w_done;
    logic [3:0]          beat_cnt;

    logic [ID_W-1:0]     id_q;
    logic                r_match, b_match;
    logic [4:0]          beat_num, beats_exp;
    logic                len_err;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (state == IDLE),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign any_grant = |arb_grant;
    assign req_ready = (state == IDLE) ? arb_grant : '0;
    assign busy      = (state != IDLE);

    assign id_q    = ID_W'(gnt_q);
    assign r_match = rvalid && (rid == id_q);
    assign b_match = bvalid && (bid == id_q);

    // Beat-count check: RLAST must land exactly on the expected beat; a
    // missing RLAST flags every beat from the expected last one onward.
    assign beat_num  = {1'b0, beat_cnt} + 5'd1;
    assign beats_exp = burst_q ? 5'(BURST_LEN) : 5'd1;
    assign len_err   = rlast ? (beat_num != beats_exp) : (beat_num >= beats_exp);

    always_comb begin
        state_nxt  = state;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        resp_valid = '0;
        resp_data  = '0;
        resp_last  = 1'b0;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                if (any_grant) state_nxt = req_write[arb_idx] ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (r_match) begin
                    resp_valid[gnt_q] = 1'b1;
                    resp_data         = rdata;
                    resp_last         = rlast;
                    resp_err          = (rresp != AXI_RESP_OKAY) || len_err;
                    if (rlast) state_nxt = IDLE;
                end
            end
            WR_REQ: begin
                // Each channel drops its valid after its own handshake, so W
                // may complete before AW (or vice versa) without stalling.
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (b_match) begin
                    resp_valid[gnt_q] = 1'b1;
                    resp_last         = 1'b1;
                    resp_err          = (bresp != AXI_RESP_OKAY);
                    state_nxt         = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payloads are zero whenever their valid is low.
    assign arid    = arvalid ? id_q : '0;
    assign araddr  = arvalid ? addr_q : '0;
    assign arlen   = arvalid ? (burst_q ? 8'(BURST_LEN - 1) : 8'd0) : 8'd0;
    assign arsize  = arvalid ? AXSIZE : 3'd0;
    assign arburst = arvalid ? AXI_BURST_INCR : 2'b00;
    assign awid    = awvalid ? id_q : '0;
    assign awaddr  = awvalid ? addr_q : '0;
    assign awlen   = 8'd0;
    assign awsize  = awvalid ? AXSIZE : 3'd0;
    assign awburst = awvalid ? AXI_BURST_INCR : 2'b00;
    assign wdata   = wvalid ? wdata_q : '0;
    assign wstrb   = wvalid ? strb_q : '0;
    assign wlast   = wvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            burst_q  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_grant) begin
                        gnt_q    <= arb_idx;
                        addr_q   <= req_addr[arb_idx*ADDR_W +: ADDR_W];
                        wdata_q  <= req_wdata[arb_idx*DATA_W +: DATA_W];
                        strb_q   <= req_strb[arb_idx*STRB_W +: STRB_W];
                        burst_q  <= req_burst[arb_idx] && !req_write[arb_idx];
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        beat_cnt <= '0;
                    end
                end
                RD_DATA: begin
                    if (r_match && beat_cnt != 4'hF) beat_cnt <= beat_cnt + 4'd1;
                end
                WR_REQ: begin
                    if (awvalid && awready) aw_done <= 1'b1;
                    if (wvalid && wready)   w_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_multi_master.sv
// Directed scoreboard bench for axi_multi_master (NUM_REQ=2, 32-bit data,
// BURST_LEN=4). Stimulus pushes expected grants, AR/AW/W beats and responses
// into queues; a negedge monitor pops and compares whenever the DUT shows one.
module tb_axi_multi_master;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 4;
    localparam int STRB_W  = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid, req_write, req_burst, req_ready, resp_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*STRB_W-1:0] req_strb;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_last, resp_err, busy;
    logic [ID_W-1:0]           arid, rid, awid, bid;
    logic [ADDR_W-1:0]         araddr, awaddr;
    logic [7:0]                arlen, awlen;
    logic [2:0]                arsize, awsize;
    logic [1:0]                arburst, awburst, rresp, bresp;
    logic                      arvalid, arready, rlast, rvalid, rready;
    logic                      awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DATA_W-1:0]         rdata, wdata;
    logic [STRB_W-1:0]         wstrb;

    always #5 clk = ~clk;

    axi_multi_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_burst(req_burst),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_last(resp_last), .resp_err(resp_err), .busy(busy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] data;
        logic        last;
        logic        err;
        logic        chk_data;
    } resp_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } addr_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } wbeat_t;

    resp_t      exp_resp[$];
    addr_t      exp_ar[$];
    addr_t      exp_aw[$];
    wbeat_t     exp_w[$];
    logic [1:0] exp_gnt[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: expected DUT event never occurred (got none, required one)", name);
    endtask

    // ---------------- monitor ----------------
    resp_t      m_resp_e, m_resp_g;
    addr_t      m_addr_e;
    wbeat_t     m_w_e;
    logic [1:0] m_gnt_e;

    always @(negedge clk) begin
        if (req_ready != '0) begin
            if (exp_gnt.size() == 0) check("unexpected_grant", req_ready, 0);
            else begin
                m_gnt_e = exp_gnt.pop_front();
                check("grant", req_ready, m_gnt_e);
            end
        end
        if (arvalid && arready) begin
            if (exp_ar.size() == 0) check("unexpected_ar", araddr, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                m_addr_e = exp_ar.pop_front();
                check("ar", {arid, araddr, arlen, arsize, arburst}, m_addr_e);
            end
        end
        if (awvalid && awready) begin
            if (exp_aw.size() == 0) check("unexpected_aw", awaddr, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                m_addr_e = exp_aw.pop_front();
                check("aw", {awid, awaddr, awlen, awsize, awburst}, m_addr_e);
            end
        end
        if (wvalid && wready) begin
            if (exp_w.size() == 0) check("unexpected_w", wdata, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                m_w_e = exp_w.pop_front();
                check("w", {wdata, wstrb, wlast}, m_w_e);
            end
        end
        if (resp_valid != '0) begin
            if (exp_resp.size() == 0) check("unexpected_resp", resp_valid, 0);
            else begin
                m_resp_e          = exp_resp.pop_front();
                m_resp_g.port     = resp_valid;
                m_resp_g.data     = m_resp_e.chk_data ? resp_data : 32'h0;
                m_resp_g.last     = resp_last;
                m_resp_g.err      = resp_err;
                m_resp_g.chk_data = m_resp_e.chk_data;
                check("resp", m_resp_g, m_resp_e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_write = '0; req_burst = '0;
        req_addr  = '0; req_wdata = '0; req_strb  = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
        bvalid = 1'b0; bid = '0; bresp = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic request(input int p, input logic wr, input logic bu,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid[p]               = 1'b1;
        req_write[p]               = wr;
        req_burst[p]               = bu;
        req_addr[p*ADDR_W +: ADDR_W] = a;
        req_wdata[p*DATA_W +: DATA_W] = d;
        req_strb[p*STRB_W +: STRB_W]  = s;
    endtask

    task automatic wait_grant(input int p);
        #1;
        for (int i = 0; i < 40; i++) begin
            if (req_ready[p]) begin
                tick();
                req_valid[p] = 1'b0;
                return;
            end
            tick();
        end
        timeout("grant_wait");
        req_valid[p] = 1'b0;
    endtask

    task automatic ar_accept();
        for (int i = 0; i < 40 && !arvalid; i++) tick();
        if (!arvalid) timeout("arvalid_wait");
        else begin
            arready = 1'b1;
            tick();
            arready = 1'b0;
        end
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] d,
                          input logic [1:0] resp, input logic last);
        rvalid = 1'b1; rid = id; rdata = d; rresp = resp; rlast = last;
        tick();
        rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    endtask

    function automatic addr_t ar_vec(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
        return '{id: id, addr: a, len: len, size: 3'd2, burst: 2'b01};
    endfunction

    function automatic resp_t rd_vec(input logic [1:0] port, input logic [31:0] d,
                                     input logic last, input logic err);
        return '{port: port, data: d, last: last, err: err, chk_data: 1'b1};
    endfunction

    // ---------------- directed tests ----------------
    initial begin
        do_reset();

        // Reset state: every output zero.
        check("reset_ctrl", {busy, req_ready, resp_valid, resp_last, resp_err,
                             arvalid, rready, awvalid, wvalid, wlast, bready}, 0);
        check("reset_ar", {arid, araddr, arlen, arsize, arburst}, 0);
        check("reset_aw_w", {awid, awaddr, awlen, awsize, awburst, wstrb}, 0);
        check("reset_data", {resp_data, wdata}, 0);

        // T1: port1 single read while port0 idle.
        exp_gnt.push_back(2'b10);
        exp_ar.push_back(ar_vec(4'd1, 32'h0000_1000, 8'd0));
        exp_resp.push_back(rd_vec(2'b10, 32'hDEAD_BEEF, 1'b1, 1'b0));
        request(1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        wait_grant(1);
        check("t1_busy_in_rd_addr", busy, 1);
        ar_accept();
        check("t1_rready", rready, 1);
        r_beat(4'd1, 32'hDEAD_BEEF, 2'b00, 1'b1);
        check("t1_idle_after", busy, 0);

        // T2: both ports from reset -> port0, then port1 (port0 re-requests
        // while busy), then port0 again.
        do_reset();
        exp_gnt.push_back(2'b01);
        exp_gnt.push_back(2'b10);
        exp_gnt.push_back(2'b01);
        exp_ar.push_back(ar_vec(4'd0, 32'h0000_2000, 8'd0));
        exp_ar.push_back(ar_vec(4'd1, 32'h0000_3000, 8'd0));
        exp_ar.push_back(ar_vec(4'd0, 32'h0000_2100, 8'd0));
        exp_resp.push_back(rd_vec(2'b01, 32'h2222_0000, 1'b1, 1'b0));
        exp_resp.push_back(rd_vec(2'b10, 32'h3333_0000, 1'b1, 1'b0));
        exp_resp.push_back(rd_vec(2'b01, 32'h2222_0100, 1'b1, 1'b0));
        request(0, 1'b0, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
        request(1, 1'b0, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
        wait_grant(0);
        request(0, 1'b0, 1'b0, 32'h0000_2100, 32'h0, 4'h0);
        check("t2_no_grant_while_busy", req_ready, 0);
        ar_accept();
        r_beat(4'd0, 32'h2222_0000, 2'b00, 1'b1);
        wait_grant(1);
        ar_accept();
        r_beat(4'd1, 32'h3333_0000, 2'b00, 1'b1);
        wait_grant(0);
        ar_accept();
        r_beat(4'd0, 32'h2222_0100, 2'b00, 1'b1);

        // T3: port0 burst read, RVALID every other cycle.
        exp_gnt.push_back(2'b01);
        exp_ar.push_back(ar_vec(4'd0, 32'h0000_0100, 8'd3));
        for (int k = 0; k < 4; k++)
            exp_resp.push_back(rd_vec(2'b01, 32'hA000_0000 + 32'(k), 1'(k == 3), 1'b0));
        request(0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
        wait_grant(0);
        ar_accept();
        for (int k = 0; k < 4; k++) begin
            r_beat(4'd0, 32'hA000_0000 + 32'(k), 2'b00, 1'(k == 3));
            if (k < 3) tick();
        end
        check("t3_idle_after", busy, 0);

        // T4: port1 write, WREADY two cycles before AWREADY, BRESP=SLVERR.
        exp_gnt.push_back(2'b10);
        exp_aw.push_back(ar_vec(4'd1, 32'h0000_0200, 8'd0));
        exp_w.push_back('{data: 32'h1234_5678, strb: 4'b0011, last: 1'b1});
        exp_resp.push_back('{port: 2'b10, data: 32'h0, last: 1'b1, err: 1'b1, chk_data: 1'b0});
        request(1, 1'b1, 1'b0, 32'h0000_0200, 32'h1234_5678, 4'b0011);
        wait_grant(1);
        check("t4_aw_w_together", {awvalid, wvalid}, 2'b11);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        check("t4_w_dropped_aw_held", {awvalid, wvalid}, 2'b10);
        tick();
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check("t4_bready", {bready, awvalid, wvalid}, 3'b100);
        bvalid = 1'b1; bid = 4'd1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bid = '0; bresp = '0;
        check("t4_idle_after", busy, 0);

        // T5: port0 burst with a foreign RID=3 beat (even with RLAST) between
        // beats 2 and 3; it is dropped and the burst continues.
        exp_gnt.push_back(2'b01);
        exp_ar.push_back(ar_vec(4'd0, 32'h0000_0400, 8'd3));
        for (int k = 0; k < 4; k++)
            exp_resp.push_back(rd_vec(2'b01, 32'hB000_0000 + 32'(k), 1'(k == 3), 1'b0));
        request(0, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 4'h0);
        wait_grant(0);
        ar_accept();
        r_beat(4'd0, 32'hB000_0000, 2'b00, 1'b0);
        r_beat(4'd0, 32'hB000_0001, 2'b00, 1'b0);
        r_beat(4'd3, 32'hBAD0_BAD0, 2'b00, 1'b1);
        check("t5_busy_after_foreign", busy, 1);
        r_beat(4'd0, 32'hB000_0002, 2'b00, 1'b0);
        r_beat(4'd0, 32'hB000_0003, 2'b00, 1'b1);
        check("t5_idle_after", busy, 0);

        // T6: reset mid-burst after the 2nd beat, then a normal read.
        exp_gnt.push_back(2'b10);
        exp_ar.push_back(ar_vec(4'd1, 32'h0000_0800, 8'd3));
        exp_resp.push_back(rd_vec(2'b10, 32'hC000_0000, 1'b0, 1'b0));
        exp_resp.push_back(rd_vec(2'b10, 32'hC000_0001, 1'b0, 1'b0));
        request(1, 1'b0, 1'b1, 32'h0000_0800, 32'h0, 4'h0);
        wait_grant(1);
        ar_accept();
        r_beat(4'd1, 32'hC000_0000, 2'b00, 1'b0);
        r_beat(4'd1, 32'hC000_0001, 2'b00, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_rst_outputs", {busy, rready, resp_valid, arvalid, awvalid, wvalid, bready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_gnt.push_back(2'b01);
        exp_ar.push_back(ar_vec(4'd0, 32'h0000_0500, 8'd0));
        exp_resp.push_back(rd_vec(2'b01, 32'h5555_AAAA, 1'b1, 1'b0));
        request(0, 1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
        wait_grant(0);
        ar_accept();
        r_beat(4'd0, 32'h5555_AAAA, 2'b00, 1'b1);

        // T7: burst with SLVERR on beat 1 and RLAST early on beat 2.
        exp_gnt.push_back(2'b01);
        exp_ar.push_back(ar_vec(4'd0, 32'h0000_0C00, 8'd3));
        exp_resp.push_back(rd_vec(2'b01, 32'hD000_0000, 1'b0, 1'b1));
        exp_resp.push_back(rd_vec(2'b01, 32'hD000_0001, 1'b1, 1'b1));
        request(0, 1'b0, 1'b1, 32'h0000_0C00, 32'h0, 4'h0);
        wait_grant(0);
        ar_accept();
        r_beat(4'd0, 32'hD000_0000, 2'b10, 1'b0);
        r_beat(4'd0, 32'hD000_0001, 2'b00, 1'b1);
        check("t7_early_last_idle", busy, 0);

        // T8: single read whose first beat lacks RLAST: error, keep waiting.
        exp_gnt.push_back(2'b01);
        exp_ar.push_back(ar_vec(4'd0, 32'h0000_0E00, 8'd0));
        exp_resp.push_back(rd_vec(2'b01, 32'hE000_0000, 1'b0, 1'b1));
        exp_resp.push_back(rd_vec(2'b01, 32'hE000_0001, 1'b1, 1'b1));
        request(0, 1'b0, 1'b0, 32'h0000_0E00, 32'h0, 4'h0);
        wait_grant(0);
        ar_accept();
        r_beat(4'd0, 32'hE000_0000, 2'b00, 1'b0);
        check("t8_busy_until_rlast", busy, 1);
        r_beat(4'd0, 32'hE000_0001, 2'b00, 1'b1);
        check("t8_idle_after", busy, 0);

        repeat (3) tick();
        check("left_resp", 64'(exp_resp.size()), 0);
        check("left_ar", 64'(exp_ar.size()), 0);
        check("left_aw_w", 64'(exp_aw.size() + exp_w.size()), 0);
        check("left_grant", 64'(exp_gnt.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (got hang, required completion)");
        $fatal(1, "watchdog");
    end

endmodule
